// File: rtl/gain_st_pkg.sv
// Shared types, widths and the saturating scale helper for the
// multi-channel ISI gain stage.
package gain_st_pkg;

  localparam int NCH       = 4;
  localparam int BIT_ISI   = 8;
  localparam int BIT_GAIN  = 6;
  localparam int GAIN_FRAC = 2;
  localparam int BIT_DROP  = 8;
  localparam int CH_W      = $clog2(NCH);
  localparam int P_W       = BIT_ISI + BIT_GAIN;

  typedef logic [BIT_ISI-1:0]  isi_t;
  typedef logic [BIT_GAIN-1:0] gain_t;
  typedef logic [CH_W-1:0]     ch_t;
  typedef logic [BIT_DROP-1:0] drop_t;

  localparam gain_t UNITY_GAIN = BIT_GAIN'(1 << GAIN_FRAC);

  typedef struct packed {
    ch_t  ch;
    isi_t isi;
  } out_t;

  // Full-width product, drop the fraction, clamp to all-ones.
  function automatic isi_t sat_scale(isi_t isi, gain_t g);
    logic [P_W-1:0] p;
    logic [P_W-1:0] r;
    p = P_W'(isi) * P_W'(g);
    r = p >> GAIN_FRAC;
    return (|r[P_W-1:BIT_ISI]) ? '1 : r[BIT_ISI-1:0];
  endfunction

endpackage

// File: rtl/gain_st_if.sv
// Sample, gain-programming and output stream bundle
// for gain_st_mc.
interface gain_st_if;
  import gain_st_pkg::*;

  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         comp_addr;
  logic [NCH*BIT_ISI-1:0] in_isi;
  logic                   gain_we;
  ch_t                    gain_ch;
  gain_t                  gain_val;
  logic                   out_valid;
  logic                   out_ready;
  isi_t                   out_isi;
  ch_t                    out_ch;
  drop_t                  drop_cnt;
  logic                   drop_pulse;

  modport master (
    output in_valid, comp_addr, in_isi,
    output gain_we, gain_ch, gain_val,
    output out_ready,
    input  out_valid, out_isi, out_ch,
    input  drop_cnt, drop_pulse
  );

  modport slave (
    input  in_valid, comp_addr, in_isi,
    input  gain_we, gain_ch, gain_val,
    input  out_ready,
    output out_valid, out_isi, out_ch,
    output drop_cnt, drop_pulse
  );

endinterface

// File: rtl/gain_st_rr_arb.sv
// Round-robin arbiter: first request at or after ptr wins;
// ptr advances past the winner only when a grant is issued.
module gain_st_rr_arb
  import gain_st_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic [NCH-1:0] req,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output ch_t            idx,
  output logic           any
);

  ch_t  ptr_q, ptr_d;
  logic found;
  int   c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr_q) + i) % NCH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = CH_W'(c);
      end
    end
    ptr_d = ptr_q;
    if (en && any) begin
      gnt[idx] = 1'b1;
      ptr_d    = (int'(idx) == NCH - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gain_st_mc.sv
// Multi-channel ISI gain stage: per-channel slots, per-channel
// saturating gain, round-robin merge onto one output stream.
module gain_st_mc
  import gain_st_pkg::*;
(
  input logic  clk,
  input logic  clr,
  gain_st_if.slave bus
);

  localparam int SUM_W = BIT_DROP + 1;

  logic [NCH-1:0] full_q, full_d;
  isi_t           isi_q  [NCH];
  isi_t           isi_d  [NCH];
  gain_t          gain_q [NCH];
  gain_t          gain_d [NCH];
  out_t           out_q, out_d;
  logic           out_valid_q, out_valid_d;
  drop_t          drop_cnt_q, drop_cnt_d;
  logic           drop_pulse_q, drop_pulse_d;

  logic           free;
  logic [NCH-1:0] gnt;
  ch_t            gidx;
  logic           gany;
  logic [CH_W:0]  ndrop;
  logic [SUM_W-1:0] cnt_sum;

  assign free = !out_valid_q || bus.out_ready;

  gain_st_rr_arb u_arb (
    .clk (clk),
    .clr (clr),
    .req (full_q),
    .en  (free),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  always_comb begin
    full_d      = full_q;
    isi_d       = isi_q;
    gain_d      = gain_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ndrop       = '0;

    if (free) begin
      out_valid_d = gany;
      if (gany) begin
        out_d.ch  = gidx;
        out_d.isi = sat_scale(isi_q[gidx], gain_q[gidx]);
      end
    end

    // A granted slot empties this edge, so it can take a new sample.
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) full_d[i] = 1'b0;
      if (bus.in_valid[i] && !bus.comp_addr[i]) begin
        if (!full_q[i] || gnt[i]) begin
          full_d[i] = 1'b1;
          isi_d[i]  = bus.in_isi[i*BIT_ISI +: BIT_ISI];
        end else begin
          ndrop = ndrop + 1'b1;
        end
      end
    end

    cnt_sum      = {1'b0, drop_cnt_q} + SUM_W'(ndrop);
    drop_cnt_d   = cnt_sum[BIT_DROP] ? '1 : cnt_sum[BIT_DROP-1:0];
    drop_pulse_d = (ndrop != '0);

    if (bus.gain_we && int'(bus.gain_ch) < NCH)
      gain_d[bus.gain_ch] = bus.gain_val;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      full_q       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        isi_q[i]  <= '0;
        gain_q[i] <= UNITY_GAIN;
      end
    end else begin
      full_q       <= full_d;
      isi_q        <= isi_d;
      gain_q       <= gain_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_isi    = out_q.isi;
  assign bus.out_ch     = out_q.ch;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.drop_pulse = drop_pulse_q;

endmodule
